// File: rtl/csr_hpm_counters_pkg.sv
// Shared constants for the performance-counter CSR slice: CSR addresses,
// privilege encoding, event-select width and an address-region classifier.
package csr_hpm_counters_pkg;

    localparam logic [11:0] MCYCLE        = 12'hB00;
    localparam logic [11:0] MINSTRET      = 12'hB02;
    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] MCYCLEH       = 12'hB80;
    localparam logic [11:0] MINSTRETH     = 12'hB82;
    localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CYCLE         = 12'hC00;
    localparam logic [11:0] TIME          = 12'hC01;
    localparam logic [11:0] INSTRET       = 12'hC02;
    localparam logic [11:0] HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CYCLEH        = 12'hC80;
    localparam logic [11:0] TIMEH         = 12'hC81;
    localparam logic [11:0] INSTRETH      = 12'hC82;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;
    localparam logic [11:0] MHPMEVENT31   = 12'h33F;

    localparam int EVSEL_W = 5;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_MCNT,   // B00..B1F, B80..B9F
        RGN_UCNT,   // C00..C1F, C80..C9F
        RGN_EVT     // 323..33F
    } csr_rgn_e;

    function automatic csr_rgn_e csr_region(input logic [11:0] adr);
        csr_rgn_e r;
        r = RGN_NONE;
        if (adr[11:8] == 4'hB && adr[6:5] == 2'b00)      r = RGN_MCNT;
        else if (adr[11:8] == 4'hC && adr[6:5] == 2'b00) r = RGN_UCNT;
        else if (adr >= MHPMEVENT3 && adr <= MHPMEVENT31) r = RGN_EVT;
        return r;
    endfunction

endpackage

// File: rtl/csr_hpm_counters_counter.sv
// One 64-bit performance counter. A CSR write always beats the increment;
// with XLEN=32 each half is written separately and the untouched half is kept.
module hpm_counter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_i,
    input  logic            wrlo_i,
    input  logic            wrhi_i,
    input  logic [XLEN-1:0] wrval_i,
    output logic [63:0]     cnt_o
);

    logic [63:0] cnt_q, cnt_d, wr64;

    assign wr64 = 64'(wrval_i);

    // Next value: write (either half) suppresses the increment of the whole counter
    always_comb begin
        cnt_d = cnt_q;
        if (XLEN == 64) begin
            if (wrlo_i)     cnt_d = wr64;
            else if (inc_i) cnt_d = cnt_q + 64'd1;
        end else begin
            if (wrlo_i) cnt_d[31:0]  = wr64[31:0];
            if (wrhi_i) cnt_d[63:32] = wr64[31:0];
            if (!wrlo_i && !wrhi_i && inc_i) cnt_d = cnt_q + 64'd1;
        end
    end

    // Counter register, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_hpm_counters.sv
// Machine/user performance counters with user aliases and access checking.
// Optional feature macro HPM_COUNTERS_EN: when defined, mhpmcounter3..(2+NUM_HPM)
// and their mhpmevent selectors exist; otherwise only cycle/instret/time.
module csr_hpm_counters
    import csr_hpm_counters_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int NUM_HPM     = 4,
    parameter int S_SUPPORTED = 1,
    parameter int U_SUPPORTED = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            CSRCWriteM,
    input  logic [11:0]     CSRAdrM,
    input  logic [XLEN-1:0] CSRWriteValM,
    input  logic [1:0]      PrivilegeModeW,
    input  logic [31:0]     MCOUNTEREN_REGW,
    input  logic [31:0]     SCOUNTEREN_REGW,
    input  logic [31:0]     MCOUNTINHIBIT_REGW,
    input  logic            InstrRetiredM,
    input  logic [31:0]     HPMEventM,
    input  logic [63:0]     MTIME,
    output logic [XLEN-1:0] CSRCReadValM,
    output logic            IllegalCSRCAccessM
);

`ifdef HPM_COUNTERS_EN
    localparam int NHPM = NUM_HPM;
`else
    localparam int NHPM = 0;
`endif

    csr_rgn_e                  rgn;
    logic [4:0]                idx;
    logic                      hi;
    logic                      illegal;
    logic [31:0]               inc, wrlo, wrhi, evwr;
    logic [31:0][63:0]         cnt;
    logic [31:0][EVSEL_W-1:0]  evsel;
    logic [63:0]               rd64;

    assign rgn = csr_region(CSRAdrM);
    assign idx = CSRAdrM[4:0];   // counter index; also event index since 0x320 has zero low bits
    assign hi  = CSRAdrM[7];

    // Access check: missing address (B01/B81), high half on RV64, alias writes, alias permissions
    always_comb begin
        illegal = 1'b0;
        case (rgn)
            RGN_MCNT: illegal = (idx == 5'd1) || (hi && XLEN == 64);
            RGN_UCNT: begin
                illegal = CSRCWriteM || (hi && XLEN == 64);
                if (PrivilegeModeW != PRIV_M) begin
                    if (U_SUPPORTED == 0)          illegal = 1'b1;
                    if (!MCOUNTEREN_REGW[idx])     illegal = 1'b1;
                    if (S_SUPPORTED != 0 && PrivilegeModeW == PRIV_U && !SCOUNTEREN_REGW[idx])
                        illegal = 1'b1;
                end
            end
            default: illegal = 1'b0;
        endcase
    end

    assign IllegalCSRCAccessM = illegal;

    // Write strobes: only legal writes to machine counters / event selectors land
    always_comb begin
        wrlo = '0;
        wrhi = '0;
        evwr = '0;
        if (CSRCWriteM && !illegal) begin
            case (rgn)
                RGN_MCNT: if (hi) wrhi[idx] = 1'b1; else wrlo[idx] = 1'b1;
                RGN_EVT:  evwr[idx] = 1'b1;
                default:  ;
            endcase
        end
    end

    // Increment conditions; unimplemented selectors read 0 and so never fire
    always_comb begin
        inc    = '0;
        inc[0] = ~MCOUNTINHIBIT_REGW[0];
        inc[2] = InstrRetiredM & ~MCOUNTINHIBIT_REGW[2];
        for (int i = 3; i < 32; i++)
            inc[i] = HPMEventM[evsel[i]] & (evsel[i] != '0) & ~MCOUNTINHIBIT_REGW[i];
    end

    for (genvar i = 0; i < 32; i++) begin : g_cnt
        localparam bit IS_HPM = (i >= 3) && (i < 3 + NHPM);
        localparam bit IMPL   = (i == 0) || (i == 2) || IS_HPM;

        if (IMPL) begin : g_impl
            hpm_counter #(.XLEN(XLEN)) u_cnt (
                .clk     (clk),
                .reset   (reset),
                .inc_i   (inc[i]),
                .wrlo_i  (wrlo[i]),
                .wrhi_i  (wrhi[i]),
                .wrval_i (CSRWriteValM),
                .cnt_o   (cnt[i])
            );
        end else begin : g_none
            assign cnt[i] = '0;
        end

        if (IS_HPM) begin : g_ev
            logic [EVSEL_W-1:0] ev_q, ev_d;
            // Event selector keeps only the low select bits of a write
            always_comb begin
                ev_d = ev_q;
                if (evwr[i]) ev_d = CSRWriteValM[EVSEL_W-1:0];
            end
            // Event selector register
            always_ff @(posedge clk) begin
                if (reset) ev_q <= '0;
                else       ev_q <= ev_d;
            end
            assign evsel[i] = ev_q;
        end else begin : g_noev
            assign evsel[i] = '0;
        end
    end

    // Read mux: time comes from the platform timer, high halves shift down, illegal reads 0
    always_comb begin
        rd64 = '0;
        case (rgn)
            RGN_MCNT: rd64 = cnt[idx];
            RGN_UCNT: rd64 = (idx == 5'd1) ? MTIME : cnt[idx];
            RGN_EVT:  rd64 = 64'(evsel[idx]);
            default:  rd64 = '0;
        endcase
        if (hi)      rd64 = {32'b0, rd64[63:32]};
        if (illegal) rd64 = '0;
    end

    assign CSRCReadValM = XLEN'(rd64);

    logic unused_ok;
    assign unused_ok = ^{wrlo, wrhi, evwr, inc, HPMEventM[0], MCOUNTINHIBIT_REGW[1]};

endmodule
